// File: rtl/spi_reg_scheduler_pkg.sv
// Shared types for the SPI register write scheduler.
package spi_sched_pkg;

    // Default channel count; the scheduler itself is parameterised and may override it.
    localparam int unsigned N_CH     = 4;
    localparam int unsigned CH_IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/spi_reg_scheduler_if.sv
// Channel inputs and register-file write port of the scheduler.
interface spi_reg_scheduler_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);

    logic [DATA_W-1:0] ch_data [N_CH];
    logic [N_CH-1:0]   ch_enable;
    logic [N_CH-1:0]   ch_force;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [N_CH-1:0]   pending;
    logic              busy;
    logic [15:0]       write_count;

    // Producer of channel values, consumer of the write port.
    modport master (
        output ch_data, ch_enable, ch_force,
        input  mem_we, mem_addr, mem_wdata, pending, busy, write_count
    );

    // The scheduler itself.
    modport slave (
        input  ch_data, ch_enable, ch_force,
        output mem_we, mem_addr, mem_wdata, pending, busy, write_count
    );

endinterface

// File: rtl/spi_reg_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan N_CH candidates starting at ptr; the first hit wins.
    always_comb begin
        int unsigned cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (!grant_valid && req[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_reg_scheduler.sv
// Round-robin write scheduler feeding the SPI slave register file from sensor channels.
module spi_reg_scheduler #(
    parameter int unsigned       N_CH           = 4,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int unsigned       REFRESH_CYCLES = 50_000_000
) (
    input logic                clk,
    input logic                reset,
    spi_reg_scheduler_if.slave bus
);

    import spi_sched_pkg::*;

    localparam int unsigned      IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned      REFR_W   = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [REFR_W-1:0] REFR_LAST = REFR_W'(REFRESH_CYCLES - 1);

    sched_state_t      state, state_n;
    logic [IDX_W-1:0]  init_idx, init_idx_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [DATA_W-1:0] shadow   [N_CH];
    logic [DATA_W-1:0] shadow_n [N_CH];
    logic [N_CH-1:0]   force_q, force_n;
    logic [N_CH-1:0]   refr_q, refr_n;
    logic [REFR_W-1:0] refr_cnt, refr_cnt_n;
    logic [N_CH-1:0]   req;
    logic              refr_wrap_c;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;

    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    logic [15:0]       write_count_q, write_count_n;

    // Per-channel request: enabled and (diverged from shadow or flagged).
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            req[i] = bus.ch_enable[i] &
                     ((bus.ch_data[i] != shadow[i]) | force_q[i] | refr_q[i]);
        end
    end

    // Refresh period elapses on the last count of a running period.
    always_comb begin
        refr_wrap_c = 1'b0;
        if (REFRESH_CYCLES != 0) begin
            refr_wrap_c = (state == S_RUN) && (refr_cnt == REFR_LAST);
        end
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next-state and next-output logic for the init sweep and the run-time arbiter.
    always_comb begin
        state_n     = state;
        init_idx_n  = init_idx;
        ptr_n       = ptr;
        shadow_n    = shadow;
        force_n     = force_q | bus.ch_force;
        refr_n      = refr_q;
        refr_cnt_n  = refr_cnt;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;

        case (state)
            S_INIT: begin
                mem_we_n           = 1'b1;
                mem_addr_n         = BASE_ADDR + ADDR_W'(init_idx);
                mem_wdata_n        = bus.ch_data[init_idx];
                shadow_n[init_idx] = bus.ch_data[init_idx];
                force_n[init_idx]  = 1'b0;
                if (init_idx == LAST_IDX) begin
                    state_n    = S_RUN;
                    init_idx_n = '0;
                end else begin
                    init_idx_n = init_idx + IDX_W'(1);
                end
            end
            S_RUN: begin
                if (refr_wrap_c) begin
                    refr_cnt_n = '0;
                    refr_n     = '1;
                end else if (REFRESH_CYCLES != 0) begin
                    refr_cnt_n = refr_cnt + REFR_W'(1);
                end
                if (grant_valid) begin
                    mem_we_n            = 1'b1;
                    mem_addr_n          = BASE_ADDR + ADDR_W'(grant_idx);
                    mem_wdata_n         = bus.ch_data[grant_idx];
                    shadow_n[grant_idx] = bus.ch_data[grant_idx];
                    force_n[grant_idx]  = 1'b0;
                    // A refresh landing on this grant keeps the flag so the channel is rewritten.
                    if (!refr_wrap_c) begin
                        refr_n[grant_idx] = 1'b0;
                    end
                    ptr_n = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase

        write_count_n = mem_we_n ? write_count_q + 16'd1 : write_count_q;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_INIT;
            init_idx      <= '0;
            ptr           <= '0;
            shadow        <= '{default: '0};
            force_q       <= '0;
            refr_q        <= '0;
            refr_cnt      <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= BASE_ADDR;
            mem_wdata_q   <= '0;
            write_count_q <= '0;
        end else begin
            state         <= state_n;
            init_idx      <= init_idx_n;
            ptr           <= ptr_n;
            shadow        <= shadow_n;
            force_q       <= force_n;
            refr_q        <= refr_n;
            refr_cnt      <= refr_cnt_n;
            mem_we_q      <= mem_we_n;
            mem_addr_q    <= mem_addr_n;
            mem_wdata_q   <= mem_wdata_n;
            write_count_q <= write_count_n;
        end
    end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.write_count = write_count_q;
    assign bus.pending     = req;
    assign bus.busy        = (|req) | (state == S_INIT);

endmodule

// File: tb/tb_spi_reg_scheduler.sv
// Directed bench for spi_reg_scheduler: init sweep, arbitration, flags, refresh, reset, counter wrap.
module tb_spi_reg_scheduler;

    logic clk;
    logic reset;
    logic rst_r;
    int   checks;
    int   errors;

    spi_reg_scheduler_if #(.N_CH(4), .DATA_W(32), .ADDR_W(32)) bus ();
    spi_reg_scheduler_if #(.N_CH(4), .DATA_W(32), .ADDR_W(32)) rbus ();

    spi_reg_scheduler #(
        .N_CH           (4),
        .DATA_W         (32),
        .ADDR_W         (32),
        .BASE_ADDR      (32'h0),
        .REFRESH_CYCLES (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    spi_reg_scheduler #(
        .N_CH           (4),
        .DATA_W         (32),
        .ADDR_W         (32),
        .BASE_ADDR      (32'h0),
        .REFRESH_CYCLES (16)
    ) dut_r (
        .clk   (clk),
        .reset (rst_r),
        .bus   (rbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          expi;
        int          n;
        logic [31:0] expd;

        checks = 0;
        errors = 0;
        n      = 0;
        reset  = 1'b1;
        rst_r  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ch_data[i]  = 32'h0;
            rbus.ch_data[i] = 32'h50 + 32'(i);
        end
        bus.ch_enable  = 4'hF;
        bus.ch_force   = 4'h0;
        rbus.ch_enable = 4'hF;
        rbus.ch_force  = 4'h0;

        // Reset state
        step();
        step();
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_wc", 32'(bus.write_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);

        // Init sweep on cycles 1..4
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("init_we", 32'(bus.mem_we), 32'd1);
            check("init_addr", bus.mem_addr, 32'(i));
            check("init_wdata", bus.mem_wdata, 32'h0);
        end
        check("init_busy", 32'(bus.busy), 32'd0);
        check("init_wc", 32'(bus.write_count), 32'd4);
        check("init_pend", 32'(bus.pending), 32'd0);
        step();
        check("idle_we", 32'(bus.mem_we), 32'd0);

        // Single change on channel 2
        bus.ch_data[2] = 32'h00AB_0012;
        #1;
        check("chg_pend", 32'(bus.pending), 32'h4);
        step();
        check("chg_we", 32'(bus.mem_we), 32'd1);
        check("chg_addr", bus.mem_addr, 32'd2);
        check("chg_wdata", bus.mem_wdata, 32'h00AB_0012);
        check("chg_pend0", 32'(bus.pending), 32'd0);
        step();
        check("chg_once", 32'(bus.mem_we), 32'd0);
        check("chg_wc", 32'(bus.write_count), 32'd5);

        // Move ptr to 1 via a grant to channel 0 (ptr wraps 3 -> 0 search)
        bus.ch_data[0] = 32'h1;
        step();
        check("ptr_addr", bus.mem_addr, 32'd0);

        // Fairness: all channels change every cycle, order must be 1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                bus.ch_data[i] = 32'h1000_0000 + 32'(k * 16) + 32'(i);
            end
            step();
            expi = (1 + k) % 4;
            expd = 32'h1000_0000 + 32'(k * 16) + 32'(expi);
            check("fair_we", 32'(bus.mem_we), 32'd1);
            check("fair_addr", bus.mem_addr, 32'(expi));
            check("fair_wdata", bus.mem_wdata, expd);
        end
        // Remaining channels drain with their newest values
        for (int j = 0; j < 3; j++) begin
            step();
            check("drain_addr", bus.mem_addr, 32'(j + 1));
            check("drain_wdata", bus.mem_wdata, 32'h1000_0070 + 32'(j + 1));
        end
        check("drain_pend", 32'(bus.pending), 32'd0);
        check("drain_wc", 32'(bus.write_count), 32'd17);

        // Disabled channel keeps its diff and force flag
        bus.ch_enable  = 4'b0111;
        bus.ch_data[3] = 32'hDEAD_0003;
        #1;
        check("dis_pend", 32'(bus.pending), 32'd0);
        step();
        check("dis_we0", 32'(bus.mem_we), 32'd0);
        bus.ch_force = 4'b1000;
        step();
        bus.ch_force = 4'b0000;
        check("dis_we1", 32'(bus.mem_we), 32'd0);
        step();
        check("dis_we2", 32'(bus.mem_we), 32'd0);
        bus.ch_data[3] = 32'hDEAD_0033;
        bus.ch_enable  = 4'hF;
        #1;
        check("en_pend", 32'(bus.pending), 32'h8);
        step();
        check("en_we", 32'(bus.mem_we), 32'd1);
        check("en_addr", bus.mem_addr, 32'd3);
        check("en_wdata", bus.mem_wdata, 32'hDEAD_0033);
        step();
        check("en_once", 32'(bus.mem_we), 32'd0);
        check("en_pend0", 32'(bus.pending), 32'd0);

        // Force on unchanged channel 0
        bus.ch_force = 4'b0001;
        step();
        bus.ch_force = 4'b0000;
        check("frc_we0", 32'(bus.mem_we), 32'd0);
        check("frc_pend", 32'(bus.pending), 32'h1);
        step();
        check("frc_we", 32'(bus.mem_we), 32'd1);
        check("frc_addr", bus.mem_addr, 32'd0);
        check("frc_wdata", bus.mem_wdata, 32'h1000_0070);
        step();
        check("frc_once", 32'(bus.mem_we), 32'd0);
        check("frc_wc", 32'(bus.write_count), 32'd19);

        // Force coinciding with the grant: one write only
        bus.ch_data[1] = 32'h1111_0001;
        bus.ch_force   = 4'b0010;
        step();
        bus.ch_force = 4'b0000;
        check("fg_addr", bus.mem_addr, 32'd1);
        check("fg_wdata", bus.mem_wdata, 32'h1111_0001);
        check("fg_pend", 32'(bus.pending), 32'd0);
        step();
        check("fg_once", 32'(bus.mem_we), 32'd0);

        // Reset during a write burst
        for (int i = 0; i < 4; i++) begin
            bus.ch_data[i] = 32'h2000_0000 + 32'(i);
        end
        step();
        check("burst_addr", bus.mem_addr, 32'd2);
        reset = 1'b1;
        step();
        check("mrst_we", 32'(bus.mem_we), 32'd0);
        check("mrst_wc", 32'(bus.write_count), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("reinit_addr", bus.mem_addr, 32'(i));
            check("reinit_wdata", bus.mem_wdata, 32'h2000_0000 + 32'(i));
        end
        step();
        check("reinit_idle", 32'(bus.mem_we), 32'd0);
        check("reinit_wc", 32'(bus.write_count), 32'd4);

        // Write counter wrap
        while (bus.write_count !== 16'hFFFF && n < 70000) begin
            bus.ch_data[0] = bus.ch_data[0] + 32'd1;
            step();
            n++;
        end
        check("wc_preload", 32'(bus.write_count), 32'h0000_FFFF);
        bus.ch_data[0] = bus.ch_data[0] + 32'd1;
        step();
        check("wc_wrap_we", 32'(bus.mem_we), 32'd1);
        check("wc_wrap", 32'(bus.write_count), 32'd0);

        // Refresh instance: init on 1..4, wrap at edge 20, rewrite of all channels on 21..24
        rst_r = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c <= 4) begin
                check("rf_init_addr", rbus.mem_addr, 32'(c - 1));
                check("rf_init_we", 32'(rbus.mem_we), 32'd1);
            end else if (c >= 21 && c <= 24) begin
                check("rf_we", 32'(rbus.mem_we), 32'd1);
                check("rf_addr", rbus.mem_addr, 32'(c - 21));
                check("rf_wdata", rbus.mem_wdata, 32'h50 + 32'(c - 21));
            end else begin
                check("rf_idle", 32'(rbus.mem_we), 32'd0);
            end
        end
        check("rf_wc", 32'(rbus.write_count), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
